// File: rtl/uart_cmd_parser.sv
// Host packet decoder between uart_core and the GPU register/memory bus.
// Decodes SYNC/CMD/ADDR/[DATA]/CHK frames into single-word bus accesses and replies ACK/NAK/read data.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy,
    output logic        pkt_err
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      ACK     = 8'h06;
    localparam logic [7:0]      NAK     = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK, S_EXEC, S_WAIT_RD, S_RESP
    } state_t;

    state_t           r_state;
    logic             r_is_read;
    logic [7:0]       r_xor;
    logic [1:0]       r_byte_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [15:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_resp;
    logic [2:0]       r_resp_left;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic [15:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_mem_we;
    logic             r_mem_re;
    logic             r_busy;
    logic             r_pkt_err;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_read   <= 1'b0;
            r_xor       <= 8'h00;
            r_byte_cnt  <= 2'd0;
            r_to_cnt    <= '0;
            r_addr      <= 16'h0000;
            r_wdata     <= 32'h0;
            r_resp      <= 32'h0;
            r_resp_left <= 3'd0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 32'h0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_err   <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
            r_pkt_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy     <= 1'b0;
                    r_tx_valid <= 1'b0;
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        r_state  <= S_CMD;
                        r_busy   <= 1'b1;
                        r_xor    <= 8'h00;
                        r_to_cnt <= TO_LOAD;
                    end
                end
                S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK: begin
                    if (rx_valid) begin
                        r_to_cnt <= TO_LOAD;
                        r_xor    <= r_xor ^ rx_data;
                        case (r_state)
                            S_CMD: begin
                                if (rx_data == 8'h01 || rx_data == 8'h02) begin
                                    r_is_read <= (rx_data == 8'h02);
                                    r_state   <= S_ADDR_H;
                                end else begin
                                    r_pkt_err   <= 1'b1;
                                    r_tx_valid  <= 1'b1;
                                    r_tx_data   <= NAK;
                                    r_resp_left <= 3'd0;
                                    r_state     <= S_RESP;
                                end
                            end
                            S_ADDR_H: begin
                                r_addr[15:8] <= rx_data;
                                r_state      <= S_ADDR_L;
                            end
                            S_ADDR_L: begin
                                r_addr[7:0] <= rx_data;
                                r_byte_cnt  <= 2'd0;
                                r_state     <= r_is_read ? S_CHK : S_DATA;
                            end
                            S_DATA: begin
                                r_wdata    <= {r_wdata[23:0], rx_data};
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                                if (r_byte_cnt == 2'd3)
                                    r_state <= S_CHK;
                            end
                            S_CHK: begin
                                if (rx_data == r_xor) begin
                                    r_mem_addr <= r_addr;
                                    if (r_is_read) begin
                                        r_mem_re <= 1'b1;
                                    end else begin
                                        r_mem_we    <= 1'b1;
                                        r_mem_wdata <= r_wdata;
                                    end
                                    r_state <= S_EXEC;
                                end else begin
                                    r_pkt_err   <= 1'b1;
                                    r_tx_valid  <= 1'b1;
                                    r_tx_data   <= NAK;
                                    r_resp_left <= 3'd0;
                                    r_state     <= S_RESP;
                                end
                            end
                            default: ;
                        endcase
                    end else if (r_to_cnt == '0) begin
                        // busy is left high here so it falls one cycle after the error pulse
                        r_pkt_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_is_read) begin
                        r_state <= S_WAIT_RD;
                    end else begin
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= ACK;
                        r_resp_left <= 3'd0;
                        r_state     <= S_RESP;
                    end
                end
                S_WAIT_RD: begin
                    if (mem_rvalid) begin
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= ACK;
                        r_resp      <= mem_rdata;
                        r_resp_left <= 3'd4;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_tx_valid && tx_ready) begin
                        if (r_resp_left == 3'd0) begin
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tx_data   <= r_resp[31:24];
                            r_resp      <= {r_resp[23:0], 8'h00};
                            r_resp_left <= r_resp_left - 3'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign busy      = r_busy;
    assign pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser: packets are classified by a packet-level model and
// the observed bus strobes, error pulses and TX byte stream are compared against it.
module tb_uart_cmd_parser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 40;

    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic        pkt_err;

    uart_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy), .pkt_err(pkt_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor-owned observation state
    int          n_we = 0, n_re = 0, n_err = 0, n_txrise = 0;
    int          we_cyc = -1, re_cyc = -1, err_cyc = -1, txrise_cyc = -1;
    logic [15:0] wr_addr = 0, rd_addr = 0;
    logic [31:0] wr_data = 0;
    logic        busy_at_err = 0, busy_after_err = 0;
    bq_t         tx_log;

    initial begin
        logic p_tv, p_tr, p_we, p_re, p_err;
        logic [7:0] p_td;
        p_tv = 0; p_tr = 0; p_we = 0; p_re = 0; p_err = 0; p_td = 0;
        forever begin
            @(negedge CLK);
            if (rst) begin
                p_tv = 0; p_tr = 0; p_we = 0; p_re = 0; p_err = 0;
            end else begin
                if (mem_we || mem_re) begin
                    check_eq("strobe_excl", {63'h0, mem_we & mem_re}, 64'h0);
                    check_eq("strobe_single", {63'h0, p_we | p_re}, 64'h0);
                end
                if (mem_we) begin n_we++; we_cyc = cyc; wr_addr = mem_addr; wr_data = mem_wdata; end
                if (mem_re) begin n_re++; re_cyc = cyc; rd_addr = mem_addr; end
                if (pkt_err) begin
                    check_eq("err_single", {63'h0, p_err}, 64'h0);
                    n_err++; err_cyc = cyc; busy_at_err = busy;
                end
                if (p_err) busy_after_err = busy;
                if (p_tv && !p_tr) begin
                    check_eq("bp_valid", {63'h0, tx_valid}, 64'h1);
                    check_eq("bp_data", {56'h0, tx_data}, {56'h0, p_td});
                end
                if (tx_valid && !p_tv) begin n_txrise++; txrise_cyc = cyc; end
                if (tx_valid && tx_ready) tx_log.push_back(tx_data);
                p_tv = tx_valid; p_tr = tx_ready; p_td = tx_data;
                p_we = mem_we; p_re = mem_re; p_err = pkt_err;
            end
        end
    end

    // Packet-level reference: 0 incomplete, 1 good write, 2 good read, 3 NAK
    function automatic void model(input bq_t p, output int kind,
                                  output logic [15:0] a, output logic [31:0] d);
        int s;
        int n;
        bq_t r;
        logic [7:0] x;
        kind = 0; a = 0; d = 0; s = -1;
        foreach (p[i]) if (s < 0 && p[i] == SYNC) s = i;
        if (s < 0) return;
        for (int i = s + 1; i < p.size(); i++) r.push_back(p[i]);
        if (r.size() < 1) return;
        if (r[0] != 8'h01 && r[0] != 8'h02) begin kind = 3; return; end
        n = (r[0] == 8'h01) ? 7 : 3;
        if (r.size() < n + 1) return;
        x = 0;
        for (int i = 0; i < n; i++) x = x ^ r[i];
        if (x != r[n]) begin kind = 3; return; end
        kind = (r[0] == 8'h01) ? 1 : 2;
        a = {r[1], r[2]};
        if (kind == 1) d = {r[3], r[4], r[5], r[6]};
    endfunction

    int last_byte_cyc = 0;

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge CLK); #1;
        rx_valid = 1'b1; rx_data = b; last_byte_cyc = cyc;
        @(posedge CLK); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom);
        repeat (gap) @(posedge CLK);
    endtask

    task automatic run_pkt(input bq_t p, input int gap_max, input int rd_delay,
                           input int bp, input bit noise, input string nm);
        int kind, start, rv_cyc, bp_cnt, idle, budget, we0, re0, err0, tx0;
        logic [15:0] ea;
        logic [31:0] ew, rd;
        bq_t exp_tx;
        model(p, kind, ea, ew);
        rd = $urandom;
        case (kind)
            1: exp_tx.push_back(8'h06);
            2: begin
                exp_tx.push_back(8'h06);
                exp_tx.push_back(rd[31:24]); exp_tx.push_back(rd[23:16]);
                exp_tx.push_back(rd[15:8]);  exp_tx.push_back(rd[7:0]);
            end
            3: exp_tx.push_back(8'h15);
            default: ;
        endcase
        start = cyc; we0 = n_we; re0 = n_re; err0 = n_err; tx0 = tx_log.size();
        tx_ready = (bp == 0);
        foreach (p[i]) send_byte(p[i], (i == p.size() - 1) ? 0 : $urandom_range(gap_max, 0));
        rv_cyc = -1; bp_cnt = 0; idle = 0;
        for (budget = 0; budget < 3000; budget++) begin
            @(posedge CLK); #1;
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (re_cyc > start && rv_cyc < 0 && cyc == re_cyc + rd_delay) begin
                mem_rvalid = 1'b1; mem_rdata = rd; rv_cyc = cyc;
            end
            if (bp > 0) begin
                if (tx_valid && bp_cnt >= bp) begin tx_ready = 1'b1; bp_cnt = 0; end
                else if (tx_valid) begin tx_ready = 1'b0; bp_cnt++; end
                else tx_ready = 1'b0;
            end
            if (noise && $urandom_range(3, 0) == 0) begin
                rx_valid = 1'b1; rx_data = 8'($urandom_range(8'hA4, 0));
            end else rx_valid = 1'b0;
            if (tx_log.size() - tx0 >= exp_tx.size() && !busy && !tx_valid) idle++;
            else idle = 0;
            if (idle >= 4) break;
        end
        rx_valid = 1'b0; mem_rvalid = 1'b0; tx_ready = 1'b1;
        check_eq({nm, "_budget"}, 64'(budget < 3000), 64'h1);
        check_eq({nm, "_txlen"}, 64'(tx_log.size() - tx0), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && tx0 + i < tx_log.size(); i++)
            check_eq({nm, "_txbyte"}, {56'h0, tx_log[tx0 + i]}, {56'h0, exp_tx[i]});
        check_eq({nm, "_nwe"}, 64'(n_we - we0), 64'(kind == 1));
        check_eq({nm, "_nre"}, 64'(n_re - re0), 64'(kind == 2));
        check_eq({nm, "_nerr"}, 64'(n_err - err0), 64'(kind == 3));
        if (kind == 1) begin
            check_eq({nm, "_waddr"}, {48'h0, wr_addr}, {48'h0, ea});
            check_eq({nm, "_wdata"}, {32'h0, wr_data}, {32'h0, ew});
            check_eq({nm, "_we_lat"}, 64'(we_cyc - last_byte_cyc), 64'd1);
            check_eq({nm, "_ack_lat"}, 64'(txrise_cyc - last_byte_cyc), 64'd2);
        end else if (kind == 2) begin
            check_eq({nm, "_raddr"}, {48'h0, rd_addr}, {48'h0, ea});
            check_eq({nm, "_re_lat"}, 64'(re_cyc - last_byte_cyc), 64'd1);
            check_eq({nm, "_rd_lat"}, 64'(txrise_cyc - rv_cyc), 64'd1);
        end else if (kind == 3) begin
            check_eq({nm, "_err_lat"}, 64'(err_cyc - last_byte_cyc), 64'd1);
            check_eq({nm, "_nak_lat"}, 64'(txrise_cyc - last_byte_cyc), 64'd1);
        end
        check_eq({nm, "_busy_end"}, {63'h0, busy}, 64'h0);
    endtask

    function automatic bq_t make_pkt(input int kind);
        bq_t p;
        logic [7:0] g, c, x;
        logic [31:0] w;
        for (int i = 0; i < $urandom_range(2, 0); i++) begin
            g = 8'($urandom);
            if (g == SYNC) g = 8'h00;
            p.push_back(g);
        end
        p.push_back(SYNC);
        if (kind == 3) begin
            c = 8'($urandom);
            if (c == 8'h01 || c == 8'h02) c = 8'h07;
            p.push_back(c);
            return p;
        end
        c = (kind == 0 || (kind == 2 && $urandom_range(1, 0) == 0)) ? 8'h01 : 8'h02;
        p.push_back(c);
        x = c;
        w = $urandom;
        g = 8'($urandom); p.push_back(g); x = x ^ g;
        g = 8'($urandom); p.push_back(g); x = x ^ g;
        if (c == 8'h01) begin
            p.push_back(w[31:24]); p.push_back(w[23:16]);
            p.push_back(w[15:8]);  p.push_back(w[7:0]);
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        if (kind == 2) x = x ^ (8'h01 << $urandom_range(7, 0));
        p.push_back(x);
        return p;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t p;
        int s_we, s_re, s_err, s_tx, s_rise, lat, k;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_txv",   {63'h0, tx_valid}, 64'h0);
        check_eq("rst_txd",   {56'h0, tx_data}, 64'h0);
        check_eq("rst_we",    {63'h0, mem_we}, 64'h0);
        check_eq("rst_re",    {63'h0, mem_re}, 64'h0);
        check_eq("rst_addr",  {48'h0, mem_addr}, 64'h0);
        check_eq("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        check_eq("rst_busy",  {63'h0, busy}, 64'h0);
        check_eq("rst_err",   {63'h0, pkt_err}, 64'h0);
        rst = 1'b0;
        repeat (2) @(posedge CLK);

        p = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33};
        run_pkt(p, 0, 1, 0, 0, "wr");
        p = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h12};
        run_pkt(p, 0, 3, 0, 0, "rd");
        p = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h34};
        run_pkt(p, 0, 1, 0, 0, "badchk");
        p = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33};
        run_pkt(p, 2, 1, 0, 0, "wr2");
        p = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h07};
        run_pkt(p, 1, 1, 0, 0, "badcmd");
        p = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
        run_pkt(p, 1, 2, 20, 1, "bp");

        // inter-byte timeout
        s_we = n_we; s_re = n_re; s_err = n_err; s_tx = tx_log.size(); s_rise = n_txrise;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        for (k = 0; k < TO + 20; k++) begin
            @(posedge CLK); #1;
            if (n_err > s_err && cyc > err_cyc + 1) break;
        end
        lat = err_cyc - last_byte_cyc;
        check_eq("to_nerr", 64'(n_err - s_err), 64'd1);
        check_eq("to_lat_ok", 64'(lat == TO || lat == TO + 1), 64'h1);
        check_eq("to_busy_at_err", {63'h0, busy_at_err}, 64'h1);
        check_eq("to_busy_after", {63'h0, busy_after_err}, 64'h0);
        check_eq("to_notx", 64'(n_txrise - s_rise + tx_log.size() - s_tx), 64'd0);
        check_eq("to_nostrobe", 64'(n_we - s_we + n_re - s_re), 64'd0);
        p = '{8'hA5, 8'h02, 8'hBE, 8'hEF, 8'h53};
        run_pkt(p, 0, 1, 0, 0, "after_to");

        // reset while a read response is held off by backpressure
        s_rise = n_txrise; k = cyc; tx_ready = 1'b0;
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h20, 0); send_byte(8'h22, 0);
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            mem_rvalid = (re_cyc > k && cyc == re_cyc + 2);
            mem_rdata = 32'h1234_5678;
            if (tx_valid) break;
        end
        mem_rvalid = 1'b0;
        check_eq("rst_pre_txv", {63'h0, tx_valid}, 64'h1);
        @(posedge CLK); #1;
        rst = 1'b1; #1;
        check_eq("rst_mid_txv", {63'h0, tx_valid}, 64'h0);
        check_eq("rst_mid_busy", {63'h0, busy}, 64'h0);
        repeat (2) @(posedge CLK);
        #1; rst = 1'b0; tx_ready = 1'b1;
        s_we = n_we; s_re = n_re; s_err = n_err; s_rise = n_txrise;
        repeat (10) @(posedge CLK);
        #1;
        check_eq("rst_quiet", 64'(n_we - s_we + n_re - s_re + n_err - s_err + n_txrise - s_rise), 64'd0);
        p = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33};
        run_pkt(p, 0, 1, 0, 0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            p = make_pkt($urandom_range(3, 0));
            run_pkt(p, 3, $urandom_range(6, 1),
                    ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : 0,
                    1'($urandom_range(1, 0)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser sitting directly downstream of `uart_core`: it consumes `rx_data`/`rx_valid`, decodes framed host packets, and issues single-word write/read requests to the GPU register/memory bus. Replies (ACK/NAK, read data) go back through `uart_core`'s `tx_data`/`tx_valid`/`tx_ready`. It is the host-debug entry point for loading programs and inspecting state.

## Interface

Parameters:
- `SYNC_BYTE`, 8'hA5: packet start marker.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout in `CLK` cycles (10 ms at 100 MHz); must be ≥ 2.

Ports:
- `CLK` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte from `uart_core`.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in this cycle.
- `tx_data` out 8: response byte to `uart_core`.
- `tx_valid` out 1: response byte offered.
- `tx_ready` in 1: `uart_core` accepts the byte when `tx_valid & tx_ready` at a rising edge.
- `mem_addr` out 16: bus address.
- `mem_wdata` out 32: bus write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in 32: read data, valid with `mem_rvalid`.
- `mem_rvalid` in 1: one-cycle read-return strobe, any number of cycles (≥1) after `mem_re`.
- `busy` out 1: high in every state except IDLE.
- `pkt_err` out 1: one-cycle pulse on checksum error, bad command, or timeout.

## Operation

- Packet format: SYNC, CMD, ADDR_H, ADDR_L, [D3 D2 D1 D0 when CMD=0x01], CHK. CHK = XOR of every byte from CMD through the last payload byte. SYNC is excluded.
- CMD 0x01 is a write and CMD 0x02 is a read.
- States: IDLE → CMD → ADDR_H → ADDR_L → DATA (2-bit byte counter, 4 bytes, writes only) → CHK → EXEC → (WAIT_RD for reads) → RESP → IDLE.
- IDLE: bytes other than `SYNC_BYTE` are discarded silently.
- CMD state: any byte other than 0x01 or 0x02 causes a NAK (0x15) response and a `pkt_err` pulse.
- Each accepted byte updates the running XOR. The XOR is cleared on entry to CMD.
- CHK mismatch: respond with NAK 0x15, pulse `pkt_err`, and perform no bus access.
- Good write: `mem_addr`/`mem_wdata` are driven, `mem_we` pulses for one cycle, then the response is ACK 0x06 (1 byte).
- Good read: `mem_addr` is driven and `mem_re` pulses for one cycle. The block then waits in WAIT_RD, with no timeout, for `mem_rvalid` and captures `mem_rdata`. The response is 0x06 followed by the data MSB first (5 bytes).
- RESP: bytes are presented in order. `tx_data` is held stable while `tx_valid=1 & tx_ready=0`.
- RX bytes arriving in EXEC, WAIT_RD or RESP are dropped and do not affect state.
- Timeout: in CMD through CHK, a counter is cleared on each accepted byte. Reaching `TIMEOUT_CYCLES` cycles with no byte returns the block to IDLE with a `pkt_err` pulse and no response.
- A SYNC byte arriving mid-packet is treated as ordinary payload. There is no resync.

## Timing

- Reset (async assert) values: `tx_valid`=0, `tx_data`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `pkt_err`=0; state IDLE; counters and XOR cleared.
- Reset mid-packet or mid-response: the partial packet is abandoned and no strobe is emitted after deassertion.
- All outputs are registered.
- CHK byte arrives with `rx_valid` in cycle N:
  - `mem_we` or `mem_re` is high in cycle N+1.
  - For a NAK, `pkt_err` is high in cycle N+1 and `tx_valid` is high from N+1.
- Write ACK: `tx_valid` is high from cycle N+2.
- `mem_rvalid` in cycle M: `tx_valid` with 0x06 is high from cycle M+1.
- After the handshake edge of byte k, byte k+1 is presented in the following cycle. `tx_valid` stays high between bytes of a multi-byte response.
- After the last byte's handshake edge, `tx_valid`=0 and the state is IDLE in the next cycle.
- Bad CMD: `pkt_err` and `tx_valid` are high in the cycle after the CMD byte's `rx_valid`.
- Timeout: `pkt_err` is high for one cycle; `busy` drops the cycle after.
- `mem_we` and `mem_re` are never high together and never high for two consecutive cycles.

## Test plan

- Write: A5 01 00 10 DE AD BE EF 33 → exactly one `mem_we` with `mem_addr`=0x0010 and `mem_wdata`=0xDEADBEEF; TX 0x06; `pkt_err` never pulses.
- Read: A5 02 00 10 12, with the bench returning 0xCAFEF00D three cycles after `mem_re` → TX 06 CA FE F0 0D in order; one `mem_re`.
- Bad checksum: A5 01 00 10 DE AD BE EF 34 → no `mem_we`; TX 0x15; one `pkt_err`. A following good write still succeeds.
- Garbage and bad command: 00 FF 55 then A5 07 → the first three bytes are ignored; TX 0x15 and `pkt_err` after the 07.
- Backpressure: read response with `tx_ready` low for 20 cycles per byte → bytes stay stable, none is lost or duplicated, and exactly 5 handshakes occur.
- Timeout and reset: send A5 01 00 and stall `TIMEOUT_CYCLES` → `pkt_err`, IDLE, no TX. Separately, assert `rst` during RESP → `tx_valid`=0 immediately; the next packet is decoded correctly.
